// File: rtl/mux_pkg.sv
// Shared lane geometry and FSM state encoding for the 4:1 unstriping serializer.
package mux_pkg;
    localparam int LANES = 4;
    localparam int WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/mux_lane_hold.sv
// Holding register for lanes 1..3 of an accepted group (byte plus valid bit per lane).
module mux_lane_hold
    import mux_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [LANES-2:0][WIDTH-1:0]     data_d,
    input  logic [LANES-2:0]                vld_d,
    output logic [LANES-2:0][WIDTH-1:0]     data_q,
    output logic [LANES-2:0]                vld_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            vld_q  <= '0;
        end else if (load) begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/mux4x1_unstripe.sv
// Serializes a 4-lane byte group onto one byte stream, lane 0 first, one lane per clock.
//   state | meaning
//   IDLE  | no group in flight, outputs parked at 00/0/0, ready=1
//   SEND  | emitting lane cnt of the held group; ready only on the last lane
module mux4x1_unstripe
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [LANES-1:0] valid_in,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid_out,
    output logic [1:0]       lane_idx,
    output logic             drop_err
);

    state_t                        state, state_d;
    logic [1:0]                    cnt, cnt_d;
    logic [WIDTH-1:0]              out_d;
    logic                          valid_d;
    logic [1:0]                    lane_d;
    logic                          offer, accept;
    logic [LANES-2:0][WIDTH-1:0]   hold_data;
    logic [LANES-2:0]              hold_vld;
    logic [WIDTH-1:0]              sel_data;
    logic                          sel_vld;

    assign offer  = |valid_in;
    assign ready  = (state == IDLE) || (cnt == 2'd3);
    assign accept = offer && ready;

    mux_lane_hold u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .data_d ({in3, in2, in1}),
        .vld_d  (valid_in[LANES-1:1]),
        .data_q (hold_data),
        .vld_q  (hold_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            out       <= '0;
            valid_out <= 1'b0;
            lane_idx  <= 2'd0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            out       <= out_d;
            valid_out <= valid_d;
            lane_idx  <= lane_d;
            drop_err  <= drop_err | (offer & ~ready);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (cnt == 2'd3 && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Held lane cnt+1 is the next one onto the wire.
    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        case (cnt)
            2'd0: begin sel_data = hold_data[0]; sel_vld = hold_vld[0]; end
            2'd1: begin sel_data = hold_data[1]; sel_vld = hold_vld[1]; end
            2'd2: begin sel_data = hold_data[2]; sel_vld = hold_vld[2]; end
            default: begin sel_data = '0; sel_vld = 1'b0; end
        endcase
    end

    // Invalid lanes still take their slot but present 00.
    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        lane_d  = 2'd0;
        cnt_d   = 2'd0;
        if (accept) begin
            out_d   = valid_in[0] ? in0 : '0;
            valid_d = valid_in[0];
        end else if (state == SEND && cnt != 2'd3) begin
            cnt_d   = cnt + 2'd1;
            lane_d  = cnt + 2'd1;
            out_d   = sel_vld ? sel_data : '0;
            valid_d = sel_vld;
        end
    end

endmodule

// File: tb/tb_mux4x1_unstripe.sv
// Directed bench for the 4:1 unstriping serializer with hand-computed expectations.
module tb_mux4x1_unstripe;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] valid_in;
    logic       ready;
    logic [7:0] out;
    logic       valid_out;
    logic [1:0] lane_idx;
    logic       drop_err;

    int checks = 0;
    int failures = 0;

    mux4x1_unstripe dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .valid_in  (valid_in),
        .ready     (ready),
        .out       (out),
        .valid_out (valid_out),
        .lane_idx  (lane_idx),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        valid_in = v;
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();
        reset = 1'b0;
        checks++;
        if (out !== 8'h00 || valid_out !== 1'b0 || lane_idx !== 2'd0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%h v=%b lane=%0d drop=%b want 00/0/0/0",
                     out, valid_out, lane_idx, drop_err);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || ready !== 1'b1 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_offer: got v=%b rdy=%b drop=%b want 0/1/0", valid_out, ready, drop_err);
        end
    endtask

    task automatic test_full_group();
        logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step();
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_d[i] || valid_out !== 1'b1 || lane_idx !== 2'(i) || ready !== exp_r[i]) begin
                failures++;
                $display("FAIL full_lane%0d: got out=%h v=%b lane=%0d rdy=%b want %h/1/%0d/%b",
                         i, out, valid_out, lane_idx, ready, exp_d[i], i, exp_r[i]);
            end
            step();
        end
        checks++;
        if (out !== 8'h00 || valid_out !== 1'b0 || lane_idx !== 2'd0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL full_idle: got out=%h v=%b lane=%0d rdy=%b want 00/0/0/1",
                     out, valid_out, lane_idx, ready);
        end
    endtask

    task automatic test_sparse();
        logic [7:0] exp_d [4] = '{8'h11, 8'h00, 8'h33, 8'h00};
        logic       exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        drive(4'b0101, 8'h11, 8'h22, 8'h33, 8'h44);
        step();
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_d[i] || valid_out !== exp_v[i] || lane_idx !== 2'(i)) begin
                failures++;
                $display("FAIL sparse_lane%0d: got out=%h v=%b lane=%0d want %h/%b/%0d",
                         i, out, valid_out, lane_idx, exp_d[i], exp_v[i], i);
            end
            step();
        end
        checks++;
        if (valid_out !== 1'b0 || out !== 8'h00) begin
            failures++;
            $display("FAIL sparse_idle: got out=%h v=%b want 00/0", out, valid_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        drive(4'hF, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        step();
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out !== exp_d[i] || valid_out !== 1'b1 || lane_idx !== 2'(i % 4)) begin
                failures++;
                $display("FAIL b2b_byte%0d: got out=%h v=%b lane=%0d want %h/1/%0d",
                         i, out, valid_out, lane_idx, exp_d[i], i % 4);
            end
            if (i == 3) drive(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
            else drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
            step();
        end
        checks++;
        if (valid_out !== 1'b0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got v=%b drop=%b want 0/0", valid_out, drop_err);
        end
    endtask

    task automatic test_drop();
        logic [7:0] exp_d [4] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        drive(4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
        step();
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_d[i] || valid_out !== 1'b1 || lane_idx !== 2'(i)) begin
                failures++;
                $display("FAIL drop_lane%0d: got out=%h v=%b lane=%0d want %h/1/%0d",
                         i, out, valid_out, lane_idx, exp_d[i], i);
            end
            if (i == 1) begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_ready_busy: got %b want 0", ready);
                end
                drive(4'hF, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
            end else begin
                drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
            end
            step();
        end
        checks++;
        if (valid_out !== 1'b0 || drop_err !== 1'b1) begin
            failures++;
            $display("FAIL drop_sticky: got v=%b drop=%b want 0/1", valid_out, drop_err);
        end
        step();
        step();
        checks++;
        if (drop_err !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL drop_hold: got drop=%b v=%b want 1/0", drop_err, valid_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (drop_err !== 1'b0) begin
            failures++;
            $display("FAIL drop_clear: got %b want 0", drop_err);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'hF, 8'h50, 8'h51, 8'h52, 8'h53);
        step();
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();
        checks++;
        if (out !== 8'h52 || lane_idx !== 2'd2 || valid_out !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got out=%h lane=%0d v=%b want 52/2/1", out, lane_idx, valid_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== 8'h00 || valid_out !== 1'b0 || drop_err !== 1'b0 || ready !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_cyc%0d: got out=%h v=%b drop=%b rdy=%b want 00/0/0/1",
                         i, out, valid_out, drop_err, ready);
            end
            step();
        end
    endtask

    task automatic test_reset_offer();
        reset = 1'b1;
        drive(4'hF, 8'h60, 8'h61, 8'h62, 8'h63);
        step();
        reset = 1'b0;
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        checks++;
        if (ready !== 1'b1 || valid_out !== 1'b0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL rstoffer_release: got rdy=%b v=%b drop=%b want 1/0/0", ready, valid_out, drop_err);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid_out !== 1'b0 || out !== 8'h00) begin
                failures++;
                $display("FAIL rstoffer_cyc%0d: got out=%h v=%b want 00/0", i, out, valid_out);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_full_group();
        test_sparse();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_reset_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
